// File: rtl/rtype_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rtype_exec_sequencer
// Purpose  : Multi-cycle controller that runs one R-type instruction at a
//            time: legality check, synchronous register-file read, operand
//            capture for an external combinational ALU, then write-back to
//            rd with backpressure from the write port.
// Ports    : clk, rst_n              - clock, synchronous active-low reset
//            instr_valid/ready/instr - instruction handshake
//            rf_raddr1/2, rf_rdata1/2- register-file read port (1-cycle)
//            alu_funct7/3, alu_op1/2 - registered ALU operands and function
//            alu_result              - combinational ALU result
//            rf_we/waddr/wdata       - register-file write port
//            wb_ready                - write port accepts this cycle
//            done / illegal          - retire / reject pulses
//            busy, retire_count      - status
// Revision : 1.0 - initial release
// ============================================================================
module rtype_exec_sequencer #(
    parameter logic [6:0] OPCODE_RTYPE   = 7'b0110011,
    parameter bit         ALLOW_X0_WRITE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [6:0]  alu_funct7,
    output logic [2:0]  alu_funct3,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        wb_ready,
    output logic        done,
    output logic        illegal,
    output logic        busy,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    // Opcode is only needed at accept time, so bits [6:0] are not kept.
    logic [31:7] instr_q,  instr_d;
    logic [31:0] op1_q,    op1_d;
    logic [31:0] op2_q,    op2_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] retire_q, retire_d;

    logic w_legal;
    logic w_x0_suppress;
    logic w_wb_fire;

    // R-type legality: base ops with funct7=0, or SUB/SRA with funct7=0x20.
    always_comb begin
        w_legal = 1'b0;
        if (instr[6:0] == OPCODE_RTYPE) begin
            if (instr[31:25] == 7'b0000000) begin
                w_legal = 1'b1;
            end else if (instr[31:25] == 7'b0100000 &&
                         (instr[14:12] == 3'b000 || instr[14:12] == 3'b101)) begin
                w_legal = 1'b1;
            end
        end
    end

    // A suppressed x0 write has nothing to hand the write port, so it
    // retires without waiting for wb_ready.
    assign w_x0_suppress = (instr_q[11:7] == 5'd0) && !ALLOW_X0_WRITE;
    assign w_wb_fire     = (state_q == S_WB) && (wb_ready || w_x0_suppress);

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        funct7_d = funct7_q;
        funct3_d = funct3_q;
        retire_d = retire_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr[31:7];
                    state_d = w_legal ? S_READ : S_ERR;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                // Read data arrives this cycle; freeze it with the function.
                op1_d    = rf_rdata1;
                op2_d    = rf_rdata2;
                funct7_d = instr_q[31:25];
                funct3_d = instr_q[14:12];
                state_d  = S_WB;
            end
            S_WB: begin
                if (w_wb_fire) begin
                    retire_d = retire_q + 32'd1;
                    state_d  = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            funct7_q <= '0;
            funct3_q <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            funct7_q <= funct7_d;
            funct3_q <= funct3_d;
            retire_q <= retire_d;
        end
    end

    // All outputs decode from registered state; only done sees wb_ready.
    assign instr_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign rf_raddr1    = (state_q == S_READ || state_q == S_EXEC) ? instr_q[19:15] : 5'd0;
    assign rf_raddr2    = (state_q == S_READ || state_q == S_EXEC) ? instr_q[24:20] : 5'd0;
    assign alu_funct7   = funct7_q;
    assign alu_funct3   = funct3_q;
    assign alu_op1      = op1_q;
    assign alu_op2      = op2_q;
    assign rf_we        = (state_q == S_WB) && !w_x0_suppress;
    assign rf_waddr     = instr_q[11:7];
    assign rf_wdata     = alu_result;
    assign done         = w_wb_fire;
    assign illegal      = (state_q == S_ERR);
    assign retire_count = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_rtype_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtype_exec_sequencer
// Purpose  : Self-checking bench for rtype_exec_sequencer. A directed driver
//            pushes hand-computed write-back / reject expectations into a
//            scoreboard queue; a monitor pops and compares on done/illegal.
//            Includes a synchronous-read register file and an R-type ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtype_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [6:0]  alu_funct7;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_op1, alu_op2;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_ready;
    logic        done, illegal, busy;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    rtype_exec_sequencer #(
        .OPCODE_RTYPE   (7'b0110011),
        .ALLOW_X0_WRITE (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .alu_funct7   (alu_funct7),
        .alu_funct3   (alu_funct3),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_result   (alu_result),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .wb_ready     (wb_ready),
        .done         (done),
        .illegal      (illegal),
        .busy         (busy),
        .retire_count (retire_count)
    );

    // Register file with synchronous read
    logic [31:0] regs [32];
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
    end

    // Combinational R-type ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_funct3)
            3'b000: alu_result = alu_funct7[5] ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
            3'b001: alu_result = alu_op1 << alu_op2[4:0];
            3'b010: alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            3'b011: alu_result = {31'd0, alu_op1 < alu_op2};
            3'b100: alu_result = alu_op1 ^ alu_op2;
            3'b101: alu_result = alu_funct7[5] ? 32'($signed(alu_op1) >>> alu_op2[4:0])
                                               : alu_op1 >> alu_op2[4:0];
            3'b110: alu_result = alu_op1 | alu_op2;
            default: alu_result = alu_op1 & alu_op2;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_retire = 0;

    typedef struct {
        bit          ill;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done/illegal pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done || illegal) begin
            if (done && illegal) chk("done_with_illegal", 32'd1, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_kind_illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
                chk("out_cycle", cyc, mon_e.cyc);
                if (mon_e.ill) begin
                    chk("err_rf_we", {31'd0, rf_we}, 32'd0);
                end else begin
                    chk("wb_rf_we",    {31'd0, rf_we},      {31'd0, mon_e.we});
                    chk("wb_rf_waddr", {27'd0, rf_waddr},   {27'd0, mon_e.wa});
                    chk("wb_rf_wdata", rf_wdata,            mon_e.wd);
                    chk("wb_funct7",   {25'd0, alu_funct7}, {25'd0, mon_e.f7});
                    chk("wb_funct3",   {29'd0, alu_funct3}, {29'd0, mon_e.f3});
                end
            end
        end
    end

    // Offer one instruction from an idle sequencer; returns in the cycle
    // right after the accepting edge (READ or ERR), sampled at negedge.
    task automatic issue(input logic [31:0] iw, input bit legal, input bit push,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input int stall);
        exp_t e;
        int acc;
        @(posedge clk); #1;
        chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
        if (push) begin
            e.ill = !legal;
            e.we  = we;
            e.wa  = wa;
            e.wd  = wd;
            e.f7  = iw[31:25];
            e.f3  = iw[14:12];
            e.cyc = legal ? cyc + 3 + stall : cyc + 1;
            sbq.push_back(e);
            if (legal) exp_retire++;
        end
        instr       = iw;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        instr_valid = 1'b0;
        @(negedge clk);
        if (legal) begin
            chk("read_raddr1", {27'd0, rf_raddr1}, {27'd0, iw[19:15]});
            chk("read_raddr2", {27'd0, rf_raddr2}, {27'd0, iw[24:20]});
        end
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_cycle", cyc, acc);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        wb_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready",  {31'd0, instr_ready}, 32'd1);
        chk("rst_busy",   {31'd0, busy},        32'd0);
        chk("rst_rf_we",  {31'd0, rf_we},       32'd0);
        chk("rst_retire", retire_count,         32'd0);
        chk("rst_op1",    alu_op1,              32'd0);
        chk("rst_funct7", {25'd0, alu_funct7},  32'd0);

        // add x3,x1,x2 : 5 + 7
        issue(32'h002081B3, 1'b1, 1'b1, 1'b1, 5'd3, 32'd12, 0);
        wait_idle();
        chk("retire_after_add", retire_count, exp_retire);

        // sra x5,x1,x2 : 0x80000000 >>> 4
        regs[1] = 32'h8000_0000;
        regs[2] = 32'd4;
        issue(32'h4020D2B3, 1'b1, 1'b1, 1'b1, 5'd5, 32'hF800_0000, 0);
        wait_idle();
        chk("retire_after_sra", retire_count, exp_retire);

        // funct7=0100000 funct3=100 is illegal; ready again next cycle
        issue(32'h4020C2B3, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 0);
        @(negedge clk);
        chk("err_ready_back", {31'd0, instr_ready}, 32'd1);
        chk("retire_after_err", retire_count, exp_retire);

        // Non-R-type opcode (addi) is illegal
        issue(32'h00208193, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 0);
        wait_idle();

        // add x0,x1,x2 retires in one WB cycle even with wb_ready low
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        wb_ready = 1'b0;
        issue(32'h00208033, 1'b1, 1'b1, 1'b0, 5'd0, 32'd12, 0);
        wait_idle();
        chk("retire_after_x0", retire_count, exp_retire);

        // and x4,x1,x2 : 5 & 7
        wb_ready = 1'b1;
        issue(32'h0020F233, 1'b1, 1'b1, 1'b1, 5'd4, 32'd5, 0);
        wait_idle();

        // sub x6,x1,x2 with wb_ready low for 3 WB cycles; a busy-time offer
        // of an illegal word must not be taken
        wb_ready = 1'b0;
        issue(32'h40208333, 1'b1, 1'b1, 1'b1, 5'd6, 32'hFFFF_FFFE, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        instr       = 32'h4020C2B3;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_rf_we",    {31'd0, rf_we},    32'd1);
            chk("hold_rf_waddr", {27'd0, rf_waddr}, 32'd6);
            chk("hold_rf_wdata", rf_wdata,          32'hFFFF_FFFE);
            chk("hold_no_done",  {31'd0, done},     32'd0);
            @(posedge clk); #1;
        end
        wb_ready    = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("hold_last_rf_we",    {31'd0, rf_we},    32'd1);
        chk("hold_last_rf_wdata", rf_wdata,          32'hFFFF_FFFE);
        wait_idle();
        chk("retire_after_stall", retire_count, exp_retire);

        // Reset during READ aborts; counter clears and next add retires
        issue(32'h002081B3, 1'b1, 1'b0, 1'b1, 5'd3, 32'd12, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_retire = 0;
        @(negedge clk);
        chk("abort_busy",   {31'd0, busy},  32'd0);
        chk("abort_rf_we",  {31'd0, rf_we}, 32'd0);
        chk("abort_retire", retire_count,   32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_we",  {31'd0, rf_we}, 32'd0);
        issue(32'h002081B3, 1'b1, 1'b1, 1'b1, 5'd3, 32'd12, 0);
        wait_idle();
        chk("retire_after_abort", retire_count, 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
